// File: rtl/regfile_wr_arbiter.sv
// Round-robin arbiter sharing the register-file write port among NUM_REQ requesters.
// Define REGFILE_CLEAR_EN to add a post-reset sweep that zeroes NUM_REGS registers first.
`timescale 1ns/1ps
module regfile_wr_arbiter #(
    parameter int NUM_REQ  = 4,
    parameter int ADDR_W   = 5,
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 32
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic [NUM_REQ-1:0]           req_valid,
    input  logic [NUM_REQ*ADDR_W-1:0]    req_addr,
    input  logic [NUM_REQ*DATA_W-1:0]    req_data,
    output logic [NUM_REQ-1:0]           req_ready,
    output logic                         write_enable,
    output logic [ADDR_W-1:0]            write_reg,
    output logic [DATA_W-1:0]            write_data,
    output logic [$clog2(NUM_REQ)-1:0]   grant_id,
    output logic                         busy
);

    localparam int ID_W = $clog2(NUM_REQ);

    logic                 in_clear_s;
    logic                 in_arb_s;
    logic                 clear_last_s;
    logic [ADDR_W-1:0]    clear_addr_s;

    logic                 write_enable_r, write_enable_nxt_s;
    logic [ADDR_W-1:0]    write_reg_r, write_reg_nxt_s;
    logic [DATA_W-1:0]    write_data_r, write_data_nxt_s;
    logic [ID_W-1:0]      grant_id_r, grant_id_nxt_s;
    logic [ID_W-1:0]      ptr_r, ptr_nxt_s;
    logic                 busy_r, busy_nxt_s;

    logic                 found_s;
    logic [ID_W-1:0]      pick_s;
    logic [ID_W:0]        idx_s;
    logic [NUM_REQ-1:0]   ready_s;
    logic [ADDR_W-1:0]    sel_addr_s;
    logic [DATA_W-1:0]    sel_data_s;

`ifdef REGFILE_CLEAR_EN
    localparam logic BUSY_RST = 1'b1;

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_ARB   = 1'b1
    } state_t;

    state_t            state_r, state_nxt_s;
    logic [ADDR_W-1:0] cnt_r, cnt_nxt_s;

    // Sweep state and address counter
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r <= ST_CLEAR;
            cnt_r   <= '0;
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
        end
    end

    // Sweep next-state: leave CLEAR on the edge that loads the last register
    always_comb begin
        state_nxt_s  = state_r;
        cnt_nxt_s    = cnt_r;
        clear_last_s = 1'b0;
        case (state_r)
            ST_CLEAR: begin
                clear_last_s = (cnt_r == ADDR_W'(NUM_REGS - 1));
                if (clear_last_s) begin
                    state_nxt_s = ST_ARB;
                    cnt_nxt_s   = '0;
                end else begin
                    cnt_nxt_s   = cnt_r + ADDR_W'(1);
                end
            end
            ST_ARB: begin
                state_nxt_s = ST_ARB;
            end
            default: begin
                state_nxt_s = ST_CLEAR;
                cnt_nxt_s   = '0;
            end
        endcase
    end

    assign in_clear_s   = (state_r == ST_CLEAR);
    assign in_arb_s     = (state_r == ST_ARB);
    assign clear_addr_s = cnt_r;
`else
    localparam logic BUSY_RST = 1'b0;

    assign in_clear_s   = 1'b0;
    assign in_arb_s     = 1'b1;
    assign clear_last_s = 1'b0;
    assign clear_addr_s = '0;
`endif

    // Circular first-valid search starting at ptr
    always_comb begin
        found_s = 1'b0;
        pick_s  = '0;
        idx_s   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx_s = {1'b0, ptr_r} + (ID_W + 1)'(k);
            if (idx_s >= (ID_W + 1)'(NUM_REQ)) begin
                idx_s = idx_s - (ID_W + 1)'(NUM_REQ);
            end else begin
                idx_s = idx_s;
            end
            if (!found_s && req_valid[idx_s[ID_W-1:0]]) begin
                found_s = 1'b1;
                pick_s  = idx_s[ID_W-1:0];
            end else begin
                found_s = found_s;
            end
        end
    end

    // One-hot grant and payload select for the picked requester
    always_comb begin
        ready_s    = '0;
        sel_addr_s = '0;
        sel_data_s = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pick_s == ID_W'(i)) begin
                ready_s[i] = in_arb_s & found_s;
                sel_addr_s = req_addr[i*ADDR_W +: ADDR_W];
                sel_data_s = req_data[i*DATA_W +: DATA_W];
            end else begin
                ready_s[i] = 1'b0;
            end
        end
    end

    assign req_ready = ready_s;

    // Next write-port values: sweep write, accepted request, or idle hold
    always_comb begin
        write_enable_nxt_s = 1'b0;
        write_reg_nxt_s    = write_reg_r;
        write_data_nxt_s   = write_data_r;
        grant_id_nxt_s     = grant_id_r;
        ptr_nxt_s          = ptr_r;
        busy_nxt_s         = 1'b0;
        if (in_clear_s) begin
            write_enable_nxt_s = 1'b1;
            write_reg_nxt_s    = clear_addr_s;
            write_data_nxt_s   = '0;
            busy_nxt_s         = ~clear_last_s;
        end else if (found_s) begin
            write_enable_nxt_s = 1'b1;
            write_reg_nxt_s    = sel_addr_s;
            write_data_nxt_s   = sel_data_s;
            grant_id_nxt_s     = pick_s;
            ptr_nxt_s          = (pick_s == ID_W'(NUM_REQ - 1)) ? '0 : pick_s + ID_W'(1);
        end else begin
            write_enable_nxt_s = 1'b0;
        end
    end

    // Registered write port, grant index, pointer and busy flag
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            write_enable_r <= 1'b0;
            write_reg_r    <= '0;
            write_data_r   <= '0;
            grant_id_r     <= '0;
            ptr_r          <= '0;
            busy_r         <= BUSY_RST;
        end else begin
            write_enable_r <= write_enable_nxt_s;
            write_reg_r    <= write_reg_nxt_s;
            write_data_r   <= write_data_nxt_s;
            grant_id_r     <= grant_id_nxt_s;
            ptr_r          <= ptr_nxt_s;
            busy_r         <= busy_nxt_s;
        end
    end

    assign write_enable = write_enable_r;
    assign write_reg    = write_reg_r;
    assign write_data   = write_data_r;
    assign grant_id     = grant_id_r;
    assign busy         = busy_r;

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Directed bench for regfile_wr_arbiter: per-cycle comparison against a queue-free
// behavioural model plus literal checks of round-robin, skip, streaming and reset cases.
`timescale 1ns/1ps
module tb_regfile_wr_arbiter;

    localparam int NUM_REQ  = 4;
    localparam int ADDR_W   = 5;
    localparam int DATA_W   = 32;
    localparam int NUM_REGS = 32;
    localparam int ID_W     = $clog2(NUM_REQ);
`ifdef REGFILE_CLEAR_EN
    localparam bit CLEAR_EN = 1'b1;
`else
    localparam bit CLEAR_EN = 1'b0;
`endif

    logic                       clock;
    logic                       reset;
    logic [NUM_REQ-1:0]         req_valid;
    logic [NUM_REQ*ADDR_W-1:0]  req_addr;
    logic [NUM_REQ*DATA_W-1:0]  req_data;
    logic [NUM_REQ-1:0]         req_ready;
    logic                       write_enable;
    logic [ADDR_W-1:0]          write_reg;
    logic [DATA_W-1:0]          write_data;
    logic [ID_W-1:0]            grant_id;
    logic                       busy;

    int n_cmp;
    int n_fail;

    regfile_wr_arbiter #(
        .NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .NUM_REGS(NUM_REGS)
    ) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_addr(req_addr), .req_data(req_data),
        .req_ready(req_ready),
        .write_enable(write_enable), .write_reg(write_reg), .write_data(write_data),
        .grant_id(grant_id), .busy(busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    function automatic int pick_fn(input logic [NUM_REQ-1:0] v, input int ptr);
        for (int k = 0; k < NUM_REQ; k++) begin
            if (v[(ptr + k) % NUM_REQ]) return (ptr + k) % NUM_REQ;
        end
        return -1;
    endfunction

    int                 m_ptr;
    int                 m_cnt;
    bit                 m_clear;
    bit                 m_we;
    int                 m_reg;
    logic [DATA_W-1:0]  m_data;
    int                 m_gid;
    int                 m_pick;
    logic [NUM_REQ-1:0] m_ready;

    always_comb begin
        m_pick  = m_clear ? -1 : pick_fn(req_valid, m_ptr);
        m_ready = '0;
        if (m_pick >= 0) m_ready[m_pick] = 1'b1;
    end

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            m_we <= 1'b0; m_reg <= 0; m_data <= '0; m_gid <= 0;
            m_ptr <= 0; m_cnt <= 0; m_clear <= CLEAR_EN;
        end else if (m_clear) begin
            m_we <= 1'b1; m_reg <= m_cnt; m_data <= '0;
            m_cnt <= m_cnt + 1;
            if (m_cnt == NUM_REGS - 1) m_clear <= 1'b0;
        end else if (m_pick >= 0) begin
            m_we   <= 1'b1;
            m_reg  <= int'(req_addr[m_pick*ADDR_W +: ADDR_W]);
            m_data <= req_data[m_pick*DATA_W +: DATA_W];
            m_gid  <= m_pick;
            m_ptr  <= (m_pick + 1) % NUM_REQ;
        end else begin
            m_we <= 1'b0;
        end
    end

    // Per-cycle comparison of every output against the model
    always @(negedge clock) begin
        check("ready", 64'(req_ready), 64'(m_ready));
        check("we", 64'(write_enable), 64'(m_we));
        check("reg", 64'(write_reg), 64'(m_reg));
        check("data", 64'(write_data), 64'(m_data));
        check("gid", 64'(grant_id), 64'(m_gid));
        check("busy", 64'(busy), 64'(m_clear));
    end

    // ---------------- directed stimulus ----------------
    task automatic set_req(input int i, input int addr, input logic [DATA_W-1:0] data);
        req_addr[i*ADDR_W +: ADDR_W] = ADDR_W'(addr);
        req_data[i*DATA_W +: DATA_W] = data;
    endtask

    // Advance to the first negedge where requesters may be served
    task automatic wait_idle();
        bit done;
        done = 1'b0;
        for (int c = 0; c < 100 && !done; c++) begin
            @(negedge clock);
            if (!busy) done = 1'b1;
        end
        check("idle_timeout", 64'(done), 64'd1);
    endtask

`ifdef REGFILE_CLEAR_EN
    // Called at posedge+1 right after reset release; checks a full sweep
    task automatic sweep_check(input int stop_at);
        @(posedge clock);
        for (int c = 0; c < NUM_REGS && c <= stop_at; c++) begin
            @(negedge clock); #1;
            check("sweep_we", 64'(write_enable), 64'd1);
            check("sweep_reg", 64'(write_reg), 64'(c));
            check("sweep_data", 64'(write_data), 64'd0);
            check("sweep_busy", 64'(busy), (c == NUM_REGS - 1) ? 64'd0 : 64'd1);
        end
    endtask
`endif

    logic [NUM_REQ-1:0] rr_exp [8];

    initial begin
        n_cmp = 0; n_fail = 0;
        rr_exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010, 4'b0100, 4'b1000};
        reset = 1'b0; req_valid = '0; req_addr = '0; req_data = '0;
        for (int i = 0; i < NUM_REQ; i++) set_req(i, i, 32'hA0 + 32'(i));

        repeat (2) @(posedge clock);
        #1;
        check("rst_we", 64'(write_enable), 64'd0);
        check("rst_reg", 64'(write_reg), 64'd0);
        check("rst_data", 64'(write_data), 64'd0);
        check("rst_gid", 64'(grant_id), 64'd0);
        check("rst_busy", 64'(busy), 64'(CLEAR_EN));

`ifdef REGFILE_CLEAR_EN
        reset = 1'b1;
        sweep_check(10);
        reset = 1'b0;
        #1;
        check("midsweep_we", 64'(write_enable), 64'd0);
        check("midsweep_busy", 64'(busy), 64'd1);
        @(posedge clock); #1;
        reset = 1'b1;
        sweep_check(NUM_REGS);
        @(negedge clock); #1;
        check("post_sweep_we", 64'(write_enable), 64'd0);
        @(posedge clock); #1;
`else
        reset = 1'b1;
`endif

        // Round robin with all four requesters valid
        req_valid = 4'b1111;
        for (int j = 0; j < 8; j++) begin
            if (j == 0) wait_idle();
            else @(negedge clock);
            #1;
            check("rr_ready", 64'(req_ready), 64'(rr_exp[j]));
            if (j > 0) begin
                check("rr_reg", 64'(write_reg), 64'((j - 1) % 4));
                check("rr_data", 64'(write_data), 64'(32'hA0 + 32'((j - 1) % 4)));
                check("rr_gid", 64'(grant_id), 64'((j - 1) % 4));
            end
        end

        // Pointer skip: grant 1, then 3 wins over 0
        @(posedge clock); #1;
        req_valid = 4'b0010;
        @(negedge clock); #1;
        check("skip_g1", 64'(req_ready), 64'b0010);
        @(posedge clock); #1;
        req_valid = 4'b1001;
        @(negedge clock); #1;
        check("skip_g3", 64'(req_ready), 64'b1000);
        @(posedge clock); #1;
        @(negedge clock); #1;
        check("skip_g0", 64'(req_ready), 64'b0001);
        check("skip_gid3", 64'(grant_id), 64'd3);
        @(posedge clock); #1;

        // Single requester 2 streams addresses 5,6,7
        req_valid = 4'b0100;
        for (int s = 0; s < 3; s++) begin
            set_req(2, 5 + s, 32'h50 + 32'(s));
            @(negedge clock); #1;
            check("single_ready", 64'(req_ready), 64'b0100);
            if (s > 0) check("single_reg", 64'(write_reg), 64'(4 + s));
            @(posedge clock); #1;
        end
        req_valid = 4'b0000;
        @(negedge clock); #1;
        check("single_we_last", 64'(write_enable), 64'd1);
        check("single_reg_last", 64'(write_reg), 64'd7);
        @(posedge clock); #1;
        @(negedge clock); #1;
        check("idle_we", 64'(write_enable), 64'd0);
        check("idle_reg_hold", 64'(write_reg), 64'd7);
        check("idle_data_hold", 64'(write_data), 64'h52);
        check("idle_gid_hold", 64'(grant_id), 64'd2);

        // Reset the cycle after a handshake
        @(posedge clock); #1;
        req_valid = 4'b0110;
        @(negedge clock); #1;
        check("pre_rst_ready", 64'(req_ready), 64'b0010);
        @(posedge clock); #1;
        check("inflight_we", 64'(write_enable), 64'd1);
        reset = 1'b0;
        #1;
        check("async_we", 64'(write_enable), 64'd0);
        check("async_reg", 64'(write_reg), 64'd0);
        check("async_gid", 64'(grant_id), 64'd0);
        @(posedge clock); #3;
        for (int i = 0; i < NUM_REQ; i++) set_req(i, i, 32'hA0 + 32'(i));
        req_valid = 4'b1111;
        reset = 1'b1;
`ifdef REGFILE_CLEAR_EN
        wait_idle();
`else
        @(negedge clock);
`endif
        #1;
        check("post_rst_ready", 64'(req_ready), 64'b0001);
        @(posedge clock); #1;
        req_valid = 4'b0000;
        @(negedge clock); #1;
        check("post_rst_we", 64'(write_enable), 64'd1);
        check("post_rst_reg", 64'(write_reg), 64'd0);
        check("post_rst_data", 64'(write_data), 64'hA0);
        @(posedge clock); #1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/regfile_wr_arbiter.md
# regfile_wr_arbiter

Shares the single write port of the 32×32 register file among NUM_REQ write requesters using round-robin arbitration with a valid/ready handshake. All write-port outputs are registered and drive the register file's `write_enable`/`write_reg`/`write_data` directly. An optional post-reset sweep zeroes every register before requesters are served.

## Interface
- `NUM_REQ`, default 4: number of requesters, 2..8.
- `ADDR_W`, default 5: register address width.
- `DATA_W`, default 32: data width.
- `NUM_REGS`, default 32: registers swept by the clear sequence, ≤ 2^ADDR_W.

Ports:
- `clock`  in  1: single clock, rising edge.
- `reset`  in  1: asynchronous, active-low reset.
- `req_valid`  in  NUM_REQ: request i pending.
- `req_addr`  in  NUM_REQ*ADDR_W: request i address in slice [i*ADDR_W +: ADDR_W].
- `req_data`  in  NUM_REQ*DATA_W: request i data in slice [i*DATA_W +: DATA_W].
- `req_ready`  out  NUM_REQ: one-hot combinational grant, valid this cycle.
- `write_enable`  out  1: register file write strobe, registered.
- `write_reg`  out  ADDR_W: register file write address, registered.
- `write_data`  out  DATA_W: register file write data, registered.
- `grant_id`  out  $clog2(NUM_REQ): index of the last accepted requester, registered.
- `busy`  out  1: clear sweep in progress, registered.

## Operation
- States are CLEAR and ARB. Reset enters CLEAR when the macro is defined, otherwise ARB.
- CLEAR:
  - `req_ready` = 0.
  - Each edge loads `write_enable`=1, `write_reg`=cnt, `write_data`=0, then cnt++.
  - The edge that loads cnt==NUM_REGS-1 moves to ARB and clears `busy`.
- ARB:
  - Pick the first i with `req_valid[i]`=1, searching circularly from `ptr`.
  - Drive `req_ready[i]`=1 combinationally for the picked i only; this forms the handshake.
  - On handshake the edge loads `write_enable`=1, `write_reg`=req_addr[i], `write_data`=req_data[i], `grant_id`=i, and sets `ptr`=(i+1) mod NUM_REQ.
  - With no valid request: `write_enable` loads 0, `write_reg`/`write_data`/`grant_id`/`ptr` hold.
- Requesters hold valid/addr/data stable until ready. Dropping valid without ready is allowed; the request is discarded.
- Exactly one write per cycle at most. Address conflicts are not checked; program order across requesters is not guaranteed.

## Timing
- Reset values: `write_enable`=0, `write_reg`=0, `write_data`=0, `grant_id`=0, `ptr`=0, cnt=0. `busy`=1 with the macro, 0 without.
- Latency: handshake in cycle N gives `write_enable` high in cycle N+1. The register file captures the write at the edge ending cycle N+1.
- Throughput: one accepted request per cycle, sustained.
- Clear sweep: `write_enable` is high for exactly NUM_REGS consecutive cycles, starting the cycle after the first edge following reset release. `busy` falls in the cycle after the last clear write is loaded; `req_ready` can assert in that same cycle.
- Reset asserted mid-sweep or mid-arbitration:
  - All outputs return to reset values immediately (asynchronous).
  - A sweep restarts at register 0.
  - Any in-flight registered write is dropped.
- ptr wraps from NUM_REQ-1 to 0.

## Configuration
- `REGFILE_CLEAR_EN` defined:
  - CLEAR state, cnt and sweep logic are present.
  - `busy` resets to 1 and deasserts after NUM_REGS writes.
- `REGFILE_CLEAR_EN` undefined:
  - No CLEAR state; reset enters ARB.
  - `busy` is tied 0.
  - The first request can be accepted in the first cycle after reset release.

## Test plan
- Clear sweep (macro on): release reset → `write_enable`=1 with `write_reg`=0..31 and `write_data`=0 on 32 consecutive cycles. `busy` then 0, and all register reads return 0.
- Round-robin: all four `req_valid`=1 held, addr=i, data=0xA0+i → grants 0,1,2,3,0,… one per cycle. Each `write_reg`/`write_data`/`grant_id` matches the grant, one cycle later.
- Pointer skip: after grant 1, only requesters 0 and 3 valid → 3 is granted before 0.
- Single requester: requester 2 streams addr 5,6,7 with valid held → ready on 3 consecutive cycles and 3 consecutive writes. Then valid=0 → `write_enable`=0 and outputs hold.
- Reset mid-sweep: assert `reset` at clear cnt=10, release → sweep restarts at `write_reg`=0 and runs 32 writes.
- Reset mid-stream: assert `reset` the cycle after a handshake → no write reaches the register file, `write_enable`=0 immediately, and after release `ptr`=0 so requester 0 wins first.
